// File: rtl/ula_seq_n_bits_if.sv
// Handshake and operand/result bundle for the slice-serial ULA.
// The zero/sign/ovf flags exist only when ULA_FLAGS_EN is defined.
interface ula_seq_n_bits_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       s;
    logic             m;
    logic             c_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] f;
    logic             a_eq_b;
    logic             c_out;
`ifdef ULA_FLAGS_EN
    logic             zero;
    logic             sign;
    logic             ovf;

    modport master (
        output start, a, b, s, m, c_in,
        input  ready, done, f, a_eq_b, c_out, zero, sign, ovf
    );
    modport slave (
        input  start, a, b, s, m, c_in,
        output ready, done, f, a_eq_b, c_out, zero, sign, ovf
    );
`else
    modport master (
        output start, a, b, s, m, c_in,
        input  ready, done, f, a_eq_b, c_out
    );
    modport slave (
        input  start, a, b, s, m, c_in,
        output ready, done, f, a_eq_b, c_out
    );
`endif
endinterface

// File: rtl/ula_seq_n_bits.sv
// Slice-serial 32-function ULA: one SLICE_W-bit slice per clock, LSB first.
// Define ULA_FLAGS_EN to add the zero/sign/ovf result flags.
module ula_seq_n_bits #(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    ula_seq_n_bits_if.slave bus
);
    localparam int NSL   = WIDTH / SLICE_W;
    localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg, b_reg, f_reg;
    logic [3:0]         s_reg;
    logic               m_reg;
    logic               carry_reg, eq_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               ready_reg, done_reg, a_eq_b_reg, c_out_reg;
`ifdef ULA_FLAGS_EN
    logic               zero_reg, sign_reg, ovf_reg;
`endif

    logic [SLICE_W-1:0] a_sl, b_sl, x_sl, y_sl, lg_sl, res_sl;
    logic [SLICE_W:0]   sum_sl;
    logic               carry_next, eq_next, ovf_next, last_slice;
    logic [WIDTH-1:0]   f_next;

    function automatic logic logic_bit(input logic [3:0] sel, input logic x, input logic y);
        logic r;
        r = 1'b0;
        case (sel)
            4'h0: r = ~x;
            4'h1: r = ~(x | y);
            4'h2: r = ~x & y;
            4'h3: r = 1'b0;
            4'h4: r = ~(x & y);
            4'h5: r = ~y;
            4'h6: r = x ^ y;
            4'h7: r = x & ~y;
            4'h8: r = ~x | y;
            4'h9: r = ~(x ^ y);
            4'hA: r = y;
            4'hB: r = x & y;
            4'hC: r = 1'b1;
            4'hD: r = x | ~y;
            4'hE: r = x | y;
            4'hF: r = x;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Returns {X, Y} adder operand bits for one bit position.
    function automatic logic [1:0] arith_xy(input logic [3:0] sel, input logic x, input logic y);
        logic [1:0] r;
        r = 2'b00;
        case (sel)
            4'h0: r = {x, 1'b0};
            4'h1: r = {x | y, 1'b0};
            4'h2: r = {x | ~y, 1'b0};
            4'h3: r = {1'b0, 1'b1};
            4'h4: r = {x, x & ~y};
            4'h5: r = {x | y, x & ~y};
            4'h6: r = {x, ~y};
            4'h7: r = {x & ~y, 1'b1};
            4'h8: r = {x, x & y};
            4'h9: r = {x, y};
            4'hA: r = {x | ~y, x & y};
            4'hB: r = {x & y, 1'b1};
            4'hC: r = {x, x};
            4'hD: r = {x | y, x};
            4'hE: r = {x | ~y, x};
            4'hF: r = {x, 1'b1};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    assign a_sl = a_reg[int'(idx_reg) * SLICE_W +: SLICE_W];
    assign b_sl = b_reg[int'(idx_reg) * SLICE_W +: SLICE_W];

    generate
        for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
            assign lg_sl[gi]             = logic_bit(s_reg, a_sl[gi], b_sl[gi]);
            assign {x_sl[gi], y_sl[gi]}  = arith_xy(s_reg, a_sl[gi], b_sl[gi]);
        end
    endgenerate

    assign sum_sl     = {1'b0, x_sl} + {1'b0, y_sl} + (SLICE_W + 1)'(carry_reg);
    assign res_sl     = m_reg ? lg_sl : sum_sl[SLICE_W-1:0];
    assign carry_next = m_reg ? 1'b0 : sum_sl[SLICE_W];
    // Carry into the slice MSB is recovered from the MSB sum bit and its operands.
    assign ovf_next   = m_reg ? 1'b0 :
                        (x_sl[SLICE_W-1] ^ y_sl[SLICE_W-1] ^ sum_sl[SLICE_W-1] ^ sum_sl[SLICE_W]);
    assign eq_next    = eq_reg & (a_sl == b_sl);
    assign last_slice = (idx_reg == IDX_W'(NSL - 1));

    always_comb begin
        f_next = f_reg;
        f_next[int'(idx_reg) * SLICE_W +: SLICE_W] = res_sl;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            s_reg      <= '0;
            m_reg      <= 1'b0;
            f_reg      <= '0;
            carry_reg  <= 1'b0;
            eq_reg     <= 1'b0;
            idx_reg    <= '0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            a_eq_b_reg <= 1'b0;
            c_out_reg  <= 1'b0;
`ifdef ULA_FLAGS_EN
            zero_reg   <= 1'b0;
            sign_reg   <= 1'b0;
            ovf_reg    <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_reg     <= bus.a;
                        b_reg     <= bus.b;
                        s_reg     <= bus.s;
                        m_reg     <= bus.m;
                        carry_reg <= bus.c_in & ~bus.m;
                        eq_reg    <= 1'b1;
                        idx_reg   <= '0;
                        ready_reg <= 1'b0;
                        state_reg <= RUN;
                    end else begin
                        ready_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                RUN: begin
                    f_reg     <= f_next;
                    carry_reg <= carry_next;
                    eq_reg    <= eq_next;
                    idx_reg   <= idx_reg + 1'b1;
                    if (last_slice) begin
                        state_reg  <= DONE;
                        ready_reg  <= 1'b1;
                        done_reg   <= 1'b1;
                        c_out_reg  <= carry_next;
                        a_eq_b_reg <= eq_next;
`ifdef ULA_FLAGS_EN
                        zero_reg   <= (f_next == '0);
                        sign_reg   <= f_next[WIDTH-1];
                        ovf_reg    <= ovf_next;
`endif
                    end
                end
                default: begin
                    ready_reg <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = ready_reg;
    assign bus.done   = done_reg;
    assign bus.f      = f_reg;
    assign bus.a_eq_b = a_eq_b_reg;
    assign bus.c_out  = c_out_reg;
`ifdef ULA_FLAGS_EN
    assign bus.zero   = zero_reg;
    assign bus.sign   = sign_reg;
    assign bus.ovf    = ovf_reg;
`endif
endmodule
